// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the full-speed USB transmitter.
// Contents: FSM state enum, SYNC pattern, CRC16 constants, line encodings
// as {d_plus, d_minus}, and the bit-stuffing threshold.
// Optional build macro: USB_TX_CRC16_EN adds the CRC state and step function.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
`ifdef USB_TX_CRC16_EN
        , CRC
`endif
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE    = 8'h80;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    // Line encodings, {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_LIMIT = 3'd6;

`ifdef USB_TX_CRC16_EN
    // One reflected CRC16 step for a single transmitted data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        crc16_step = fb ? ((crc >> 1) ^ CRC16_POLY_R) : (crc >> 1);
    endfunction
`endif

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// usb_tx_bit_encoder: NRZI encoder with ones counting and stuff request.
// Ports:
//   clk, n_rst   clock, synchronous active-low reset
//   load         register a new line value on this edge
//   bit_in       logical bit to encode (0 toggles the level, 1 holds it)
//   count_en     count consecutive ones (data/CRC bits); otherwise count clears
//   ovr_en       drive ovr_line instead of an encoded bit (EOP SE0/J)
//   ovr_line     override line value; an override J also returns the level to J
//   line         registered {d_plus, d_minus}
//   stuff_req    six consecutive ones have been sent; a stuffed 0 is due
module usb_tx_bit_encoder
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic       bit_in,
    input  logic       count_en,
    input  logic       ovr_en,
    input  logic [1:0] ovr_line,
    output logic [1:0] line,
    output logic       stuff_req
);

    logic       level;      // 1 = J, 0 = K
    logic       level_n;
    logic [2:0] ones_cnt;

    assign level_n   = bit_in ? level : ~level;
    assign stuff_req = (ones_cnt == STUFF_LIMIT);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            line     <= LINE_J;
            level    <= 1'b1;
            ones_cnt <= '0;
        end else if (load) begin
            if (ovr_en) begin
                line     <= ovr_line;
                ones_cnt <= '0;
                if (ovr_line == LINE_J) begin
                    level <= 1'b1;
                end
            end else begin
                level    <= level_n;
                line     <= level_n ? LINE_J : LINE_K;
                ones_cnt <= (count_en && bit_in) ? ones_cnt + 3'd1 : '0;
            end
        end
    end

endmodule

// File: rtl/usb_transmitter.sv
// usb_transmitter: full-speed USB packet transmitter (SYNC, payload, EOP).
// Pulls bytes from a first-word-fall-through FIFO, serialises LSB-first with
// bit stuffing and NRZI, and drives the USB lines directly.
// Ports:
//   clk, n_rst       clock, synchronous active-low reset
//   tx_start         one-cycle packet request (ignored while busy or FIFO empty)
//   tx_empty/tx_data FIFO status and head byte
//   tx_rd            pop strobe, high in the cycle the head byte is latched
//   d_plus/d_minus   USB lines
//   tx_busy          high from SYNC through the end of EOP
//   tx_done          one-cycle pulse after EOP
// Optional build macro: USB_TX_CRC16_EN appends an inverted CRC16 over all
// bytes after the PID when the FIFO runs empty.
module usb_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       tx_empty,
    input  logic [7:0] tx_data,
    output logic       tx_rd,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);
    import usb_tx_pkg::*;

    localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [3:0]    bit_idx, bit_idx_n, idx_inc;
    logic [7:0]    shreg, shreg_n;
    logic          tx_done_n;
    logic          end_of_bit;
    logic          fetch;

    logic          enc_load, enc_bit, enc_count, enc_ovr;
    logic [1:0]    enc_ovr_line;
    logic [1:0]    line;
    logic          stuff_req;

`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc, crc_n, crc_sh, crc_sh_n;
    logic          in_crc, in_crc_n;
    logic          first_byte, first_byte_n;
    logic          ctx_crc;
    assign ctx_crc = (state == CRC) || ((state == STUFF) && in_crc);
`endif

    assign end_of_bit = (bit_cnt == LAST_CNT);
    assign idx_inc    = bit_idx + 4'd1;

    always_comb begin
        state_n      = state;
        bit_cnt_n    = '0;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        tx_done_n    = 1'b0;
        fetch        = 1'b0;
        enc_load     = 1'b0;
        enc_bit      = 1'b0;
        enc_count    = 1'b0;
        enc_ovr      = 1'b0;
        enc_ovr_line = LINE_J;
`ifdef USB_TX_CRC16_EN
        crc_n        = crc;
        crc_sh_n     = crc_sh;
        in_crc_n     = in_crc;
        first_byte_n = first_byte;
`endif
        if (state != IDLE) begin
            bit_cnt_n = end_of_bit ? '0 : bit_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
`ifdef USB_TX_CRC16_EN
                in_crc_n = 1'b0;
`endif
                if (tx_start && !tx_empty) begin
                    state_n   = SYNC;
                    bit_idx_n = '0;
                    enc_load  = 1'b1;
                    enc_bit   = SYNC_BYTE[0];
                end
            end

            SYNC: begin
                if (end_of_bit) begin
                    if (bit_idx == 4'd7) begin
                        bit_idx_n = '0;
                        enc_load  = 1'b1;
                        if (!tx_empty) begin
                            fetch     = 1'b1;
                            shreg_n   = tx_data;
                            state_n   = DATA;
                            enc_bit   = tx_data[0];
                            enc_count = 1'b1;
`ifdef USB_TX_CRC16_EN
                            first_byte_n = 1'b1;
                            crc_n        = CRC16_INIT;
`endif
                        end else begin
                            state_n      = EOP_SE0;
                            enc_ovr      = 1'b1;
                            enc_ovr_line = LINE_SE0;
                        end
                    end else begin
                        bit_idx_n = idx_inc;
                        enc_load  = 1'b1;
                        enc_bit   = SYNC_BYTE[idx_inc[2:0]];
                    end
                end
            end

`ifdef USB_TX_CRC16_EN
            DATA, STUFF, CRC: begin
`else
            DATA, STUFF: begin
`endif
                if (end_of_bit) begin
`ifdef USB_TX_CRC16_EN
                    if (state == DATA && !first_byte) begin
                        crc_n = crc16_step(crc, shreg[bit_idx[2:0]]);
                    end
`endif
                    enc_load  = 1'b1;
                    enc_count = 1'b1;
                    // Stuffing takes priority; bit_idx is left alone so the
                    // byte-boundary fetch happens when the stuffed bit ends.
                    if (stuff_req) begin
                        state_n = STUFF;
                        enc_bit = 1'b0;
`ifdef USB_TX_CRC16_EN
                    end else if (ctx_crc) begin
                        if (bit_idx == 4'd15) begin
                            state_n      = EOP_SE0;
                            bit_idx_n    = '0;
                            enc_ovr      = 1'b1;
                            enc_ovr_line = LINE_SE0;
                        end else begin
                            state_n   = CRC;
                            bit_idx_n = idx_inc;
                            enc_bit   = crc_sh[idx_inc];
                        end
`endif
                    end else if (bit_idx == 4'd7) begin
                        bit_idx_n = '0;
                        if (!tx_empty) begin
                            fetch   = 1'b1;
                            shreg_n = tx_data;
                            state_n = DATA;
                            enc_bit = tx_data[0];
`ifdef USB_TX_CRC16_EN
                            first_byte_n = 1'b0;
`endif
                        end else begin
`ifdef USB_TX_CRC16_EN
                            state_n  = CRC;
                            in_crc_n = 1'b1;
                            crc_sh_n = ~crc_n;
                            enc_bit  = crc_sh_n[0];
`else
                            state_n      = EOP_SE0;
                            enc_ovr      = 1'b1;
                            enc_ovr_line = LINE_SE0;
`endif
                        end
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = idx_inc;
                        enc_bit   = shreg[idx_inc[2:0]];
                    end
                end
            end

            EOP_SE0: begin
                if (end_of_bit) begin
                    if (bit_idx == 4'd1) begin
                        state_n      = EOP_J;
                        bit_idx_n    = '0;
                        enc_load     = 1'b1;
                        enc_ovr      = 1'b1;
                        enc_ovr_line = LINE_J;
                    end else begin
                        bit_idx_n = idx_inc;
                    end
                end
            end

            EOP_J: begin
                if (end_of_bit) begin
                    state_n   = IDLE;
                    tx_done_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_done <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc        <= CRC16_INIT;
            crc_sh     <= '0;
            in_crc     <= 1'b0;
            first_byte <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_done <= tx_done_n;
`ifdef USB_TX_CRC16_EN
            crc        <= crc_n;
            crc_sh     <= crc_sh_n;
            in_crc     <= in_crc_n;
            first_byte <= first_byte_n;
`endif
        end
    end

    usb_tx_bit_encoder u_enc (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (enc_load),
        .bit_in    (enc_bit),
        .count_en  (enc_count),
        .ovr_en    (enc_ovr),
        .ovr_line  (enc_ovr_line),
        .line      (line),
        .stuff_req (stuff_req)
    );

    // Gated so a reset landing on a fetch cycle never pops the FIFO.
    assign tx_rd   = fetch & n_rst;
    assign tx_busy = (state != IDLE);
    assign d_plus  = line[1];
    assign d_minus = line[0];

endmodule

// File: tb/tb_usb_transmitter.sv
module tb_usb_transmitter;

    localparam int CPB = 8;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [1:0] line;
        logic       busy;
        logic       rd;
        logic       done;
    } exp_t;

    logic       clk, n_rst, tx_start, tx_empty, tx_rd;
    logic [7:0] tx_data;
    logic       d_plus, d_minus, tx_busy, tx_done;

    usb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_empty (tx_empty),
        .tx_data  (tx_data),
        .tx_rd    (tx_rd),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo[$];
    logic [1:0] s_line;
    logic       s_busy, s_rd, s_done;
    int         rd_cnt, done_cnt, busy_cnt;
    logic [1:0] hist[0:4095];

    // Model state: symbol stream (0/1 bits, 2 = SE0, 3 = J) plus byte-start marks
    int         m_sym[$];
    logic       m_bst[$];
    int         m_ones;
    int         m_data_bits;
    exp_t       exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic refresh();
        tx_empty = (fifo.size() == 0);
        tx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: sample outputs mid-cycle, then model the FIFO pop after the edge.
    task automatic cycle();
        @(negedge clk);
        s_line = {d_plus, d_minus};
        s_busy = tx_busy;
        s_rd   = tx_rd;
        s_done = tx_done;
        if (s_rd)   rd_cnt++;
        if (s_done) done_cnt++;
        if (s_busy) busy_cnt++;
        @(posedge clk);
        #1;
        if (s_rd && fifo.size() != 0) fifo.delete(0);
        refresh();
    endtask

    task automatic push_bits(input logic [15:0] v, input int nb, input logic mark_first);
        for (int b = 0; b < nb; b++) begin
            m_sym.push_back(v[b] ? 1 : 0);
            m_bst.push_back(mark_first && (b == 0));
            if (v[b]) m_ones++; else m_ones = 0;
            if (m_ones == 6) begin
                m_sym.push_back(0);
                m_bst.push_back(1'b0);
                m_ones = 0;
            end
        end
    endtask

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction
`endif

    task automatic build_model(input bq_t pkt);
        logic       lvl;
        logic [1:0] ln;
        exp_t       e;
        m_sym.delete();
        m_bst.delete();
        exp_q.delete();
        m_ones = 0;
        for (int i = 0; i < 8; i++) begin
            m_sym.push_back(i == 7 ? 1 : 0);
            m_bst.push_back(1'b0);
        end
        foreach (pkt[k]) push_bits({8'h00, pkt[k]}, 8, 1'b1);
`ifdef USB_TX_CRC16_EN
        begin
            logic [15:0] c;
            c = 16'hFFFF;
            for (int k = 1; k < pkt.size(); k++) c = crc_byte(c, pkt[k]);
            push_bits(~c, 16, 1'b0);
        end
`endif
        m_sym.push_back(2); m_bst.push_back(1'b0);
        m_sym.push_back(2); m_bst.push_back(1'b0);
        m_sym.push_back(3); m_bst.push_back(1'b0);
        m_data_bits = m_sym.size() - 11;
        lvl = 1'b1;
        for (int s = 0; s < m_sym.size(); s++) begin
            case (m_sym[s])
                0:       begin lvl = ~lvl; ln = lvl ? J : K; end
                1:       ln = lvl ? J : K;
                2:       ln = SE0;
                default: begin lvl = 1'b1; ln = J; end
            endcase
            for (int c = 0; c < CPB; c++) begin
                e.line = ln;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.rd   = (c == CPB - 1) && (s + 1 < m_sym.size()) && m_bst[s + 1];
                exp_q.push_back(e);
            end
        end
        e = '{line: J, busy: 1'b0, rd: 1'b0, done: 1'b1};
        exp_q.push_back(e);
        e = '{line: J, busy: 1'b0, rd: 1'b0, done: 1'b0};
        exp_q.push_back(e);
    endtask

    // Sends pkt and compares every cycle against the model; mid_start < 0 disables
    // the extra tx_start pulse injected during the packet.
    task automatic run_packet(input bq_t pkt, input int mid_start, input string name);
        exp_t e;
        int   n;
        fifo = pkt;
        refresh();
        build_model(pkt);
        tx_start = 1'b1;
        cycle();
        tx_start = 1'b0;
        rd_cnt = 0; done_cnt = 0; busy_cnt = 0; n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tx_start = (n == mid_start);
            cycle();
            tx_start = 1'b0;
            hist[n] = s_line;
            checks++;
            if (s_line !== e.line || s_busy !== e.busy || s_rd !== e.rd || s_done !== e.done) begin
                errors++;
                $display("FAIL %s cycle %0d: got line=%b busy=%b rd=%b done=%b, want line=%b busy=%b rd=%b done=%b",
                         name, n, s_line, s_busy, s_rd, s_done, e.line, e.busy, e.rd, e.done);
            end
            n++;
        end
        chk({name, "_rd_count"}, rd_cnt, pkt.size());
        chk({name, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        bq_t pkt;
        logic bad;
        n_rst = 1'b0; tx_start = 1'b0;
        rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
        refresh();
        repeat (3) cycle();
        chk("reset_line", s_line, J);
        chk("reset_busy", s_busy, 0);
        chk("reset_rd_done", {s_rd, s_done}, 0);
        n_rst = 1'b1;
        cycle();

        // Single PID byte
        pkt = '{8'hC3};
        run_packet(pkt, -1, "c3");
        chk("c3_first_K", hist[0], K);
        chk("c3_sync_J", hist[8], J);
        chk("c3_sync_last_K", hist[56], K);
        chk("c3_data0", hist[64], K);
        chk("c3_data2", hist[80], J);
`ifdef USB_TX_CRC16_EN
        chk("c3_busy_cycles", busy_cnt, 280);
        chk("c3_crc_bit0", hist[128], J);
        chk("c3_crc_bit1", hist[136], K);
        chk("c3_model_bits", m_data_bits, 24);
`else
        chk("c3_busy_cycles", busy_cnt, 152);
        chk("c3_se0", hist[128], SE0);
        chk("c3_eop_j", hist[144], J);
        chk("c3_model_bits", m_data_bits, 8);
`endif

        pkt = '{8'hFF, 8'hFF};
        run_packet(pkt, -1, "ffff");
`ifndef USB_TX_CRC16_EN
        chk("ffff_model_bits", m_data_bits, 18);
        chk("ffff_busy_cycles", busy_cnt, 232);
        chk("ffff_stuff1", hist[112], J);
`endif

        pkt = '{8'h3F};
        run_packet(pkt, -1, "3f");
`ifndef USB_TX_CRC16_EN
        chk("3f_stuff", hist[112], J);
        chk("3f_busy_cycles", busy_cnt, 160);
`endif

        pkt = '{8'hFC};
        run_packet(pkt, -1, "fc");
`ifndef USB_TX_CRC16_EN
        chk("fc_stuff_after_bit7", hist[128], J);
        chk("fc_se0", hist[136], SE0);
`endif

        pkt = '{8'hA5, 8'h00, 8'h7E};
        run_packet(pkt, -1, "a5007e");

        // tx_start during a packet is ignored
        pkt = '{8'h12, 8'h34};
        run_packet(pkt, 40, "midstart");

        // tx_start with empty FIFO
        fifo.delete();
        refresh();
        tx_start = 1'b1;
        cycle();
        tx_start = 1'b0;
        bad = 1'b0;
        rd_cnt = 0;
        repeat (20) begin
            cycle();
            if (s_line !== J || s_busy !== 1'b0 || s_rd !== 1'b0 || s_done !== 1'b0) bad = 1'b1;
        end
        chk("empty_start_ignored", bad, 0);

        // Reset during the second data byte
        pkt = '{8'hA5, 8'h5A, 8'h11};
        fifo = pkt;
        refresh();
        tx_start = 1'b1;
        cycle();
        tx_start = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 400 && rd_cnt < 2; i++) cycle();
        chk("rst_reached_byte2", rd_cnt, 2);
        repeat (20) cycle();
        chk("rst_busy_before", s_busy, 1);
        n_rst = 1'b0;
        cycle();
        cycle();
        chk("rst_line", s_line, J);
        chk("rst_busy", s_busy, 0);
        chk("rst_rd_done", {s_rd, s_done}, 0);
        n_rst = 1'b1;
        bad = 1'b0;
        repeat (60) begin
            cycle();
            if (s_line !== J || s_busy !== 1'b0 || s_done !== 1'b0) bad = 1'b1;
        end
        chk("rst_stays_idle", bad, 0);
        chk("rst_no_more_rd", rd_cnt, 2);
        fifo.delete();
        refresh();

        // Transmitter still works after the abandoned packet
        pkt = '{8'h5A};
        run_packet(pkt, -1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
